// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, big-endian byte stream into the
// instruction memory. It holds the downstream core in reset until the load
// completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte, which is checked in state CHK.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
    localparam state_t S_FIN = S_CHK;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_FIN = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;      // word count N
    logic [15:0]         wcnt_q, wcnt_d;    // words written so far (= next index)
    logic [1:0]          bcnt_q, bcnt_d;    // byte position within current word
    logic [23:0]         word_q, word_d;    // first three bytes of current word
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpurst_q, cpurst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic        accept;
    logic [15:0] len_n;

    assign accept = in_valid && in_ready;
    assign len_n  = {len_q[7:0], in_data};

    // Stream is open only while a load is collecting bytes.
    always_comb begin
        in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
    end

    assign busy      = in_ready;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_reset = cpurst_q;

    // Next-state, byte assembly and write-strobe generation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        // Release the core one cycle after DONE is entered, so the final
        // write lands first; grab it back as soon as a new load starts.
        cpurst_d = !((state_q == S_DONE) && !start);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    word_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = len_n;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_n;
                    if ({16'h0, len_n} > 32'(DEPTH)) state_d = S_ERR;
                    else if (len_n == 16'h0)         state_d = S_FIN;
                    else                             state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    bcnt_d = bcnt_q + 2'd1;
                    word_d = {word_q[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(wcnt_q);
                        wdata_d = {word_q, in_data};
                        wcnt_d  = wcnt_q + 16'd1;
                        // N <= DEPTH was enforced, so the index never reaches DEPTH.
                        if (wcnt_q + 16'd1 == len_q) state_d = S_FIN;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpurst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpurst_q <= cpurst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load streams plus hand-written sequences
// for reset abort and (when enabled) the checksum byte. Expected writes are
// queued when a load is driven and popped by a write monitor.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, cpu_reset, busy, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [39:0] exp_q[$];

    typedef struct packed {
        logic [3:0]  n;       // stream length in bytes
        logic [79:0] bs;      // stream, first byte in MSBs
        logic [1:0]  nw;      // expected writes
        logic [63:0] ws;      // expected words, first in MSBs
        logic        gaps;    // random in_valid gaps
        logic        exp_err;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_addr, mem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write: got %0h want %0h", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the byte is taken.
    task automatic send(input logic [7:0] b, input logic gaps);
        int k;
        if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed %b want 1 for byte %h", in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 40'(busy), 40'd1);
        chk("start_clear", {38'd0, done, error}, 40'd0);
        chk("start_cpurst", 40'(cpu_reset), 40'd1);
    endtask

    // Bytes offered after the load ends must not be taken.
    task automatic hold_closed();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("closed_ready", 40'(in_ready), 40'd0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] x;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {39'd0, in_ready}, 40'd0);
        chk("rst_flags", {36'd0, busy, done, error, mem_we}, 40'd0);
        chk("rst_cpurst", 40'(cpu_reset), 40'd1);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 40'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cpurst", 40'(cpu_reset), 40'd1);

        vt[0] = '{n: 4'd10, bs: 80'h0002_2009_0005_200A_000A, nw: 2'd2,
                  ws: 64'h20090005_200A000A, gaps: 1'b0, exp_err: 1'b0};
        vt[1] = '{n: 4'd10, bs: 80'h0002_2009_0005_200A_000A, nw: 2'd2,
                  ws: 64'h20090005_200A000A, gaps: 1'b1, exp_err: 1'b0};
        vt[2] = '{n: 4'd2, bs: 80'h0, nw: 2'd0, ws: 64'h0, gaps: 1'b0, exp_err: 1'b0};
        vt[3] = '{n: 4'd2, bs: 80'h0101_0000_0000_0000_0000, nw: 2'd0, ws: 64'h0,
                  gaps: 1'b0, exp_err: 1'b1};
        vt[4] = '{n: 4'd6, bs: 80'h0001_DEAD_BEEF_0000_0000, nw: 2'd1,
                  ws: 64'hDEADBEEF_00000000, gaps: 1'b1, exp_err: 1'b0};

        for (int i = 0; i < 5; i++) begin
            wr_cnt = 0;
            start_pulse();
            for (int k = 0; k < int'(vt[i].nw); k++)
                exp_q.push_back({8'(k), vt[i].ws[63-32*k -: 32]});
            x = 8'h00;
            for (int j = 0; j < int'(vt[i].n); j++) begin
                send(vt[i].bs[79-8*j -: 8], vt[i].gaps);
                if (j >= 2) x = x ^ vt[i].bs[79-8*j -: 8];
            end
            if (vt[i].exp_err) begin
                chk("err_flags", {38'd0, done, error}, 40'd1);
                chk("err_ready", 40'(in_ready), 40'd0);
                chk("err_cpurst", 40'(cpu_reset), 40'd1);
            end else begin
                chk("last_write", 40'(mem_we), 40'(vt[i].nw != 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
                send(x, vt[i].gaps);
`endif
                chk("done_flags", {38'd0, done, error}, 40'd2);
                chk("done_cpurst_hi", 40'(cpu_reset), 40'd1);
                @(negedge clk);
                chk("done_cpurst_lo", 40'(cpu_reset), 40'd0);
                chk("done_we_lo", 40'(mem_we), 40'd0);
            end
            hold_closed();
            chk("write_count", 40'(wr_cnt), 40'(vt[i].nw));
            chk("queue_empty", 40'(exp_q.size()), 40'd0);
        end

        // Reset two bytes into the data: nothing written, core held.
        wr_cnt = 0;
        start_pulse();
        send(8'h00, 1'b0); send(8'h02, 1'b0); send(8'h20, 1'b0); send(8'h09, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {36'd0, busy, done, error, in_ready}, 40'd0);
        chk("abort_cpurst", 40'(cpu_reset), 40'd1);
        @(negedge clk);
        chk("abort_no_write", 40'(wr_cnt), 40'd0);
        // A full load afterwards starts again from address 0.
        start_pulse();
        exp_q.push_back({8'd0, 32'h20090005});
        exp_q.push_back({8'd1, 32'h200A000A});
        x = 8'h00;
        for (int j = 0; j < 10; j++) begin
            logic [79:0] s;
            s = 80'h0002_2009_0005_200A_000A;
            send(s[79-8*j -: 8], 1'b0);
            if (j >= 2) x = x ^ s[79-8*j -: 8];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(x, 1'b0);
`endif
        @(negedge clk);
        chk("reload_done", {38'd0, done, error}, 40'd2);
        chk("reload_writes", 40'(wr_cnt), 40'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch; the word is written either way.
        for (int t = 0; t < 2; t++) begin
            wr_cnt = 0;
            start_pulse();
            exp_q.push_back({8'd0, 32'h20090005});
            send(8'h00, 1'b0); send(8'h01, 1'b0);
            send(8'h20, 1'b0); send(8'h09, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
            send((t == 0) ? 8'h2C : 8'h2D, 1'b0);
            chk("chk_flags", {38'd0, done, error}, (t == 0) ? 40'd2 : 40'd1);
            @(negedge clk);
            chk("chk_cpurst", 40'(cpu_reset), (t == 0) ? 40'd0 : 40'd1);
            chk("chk_writes", 40'(wr_cnt), 40'd1);
        end
`endif

        chk("final_queue_empty", 40'(exp_q.size()), 40'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
